mux_arb: RTL
============

# mux_arb

Parametrised N-channel arbitrating multiplexer with valid/ready handshakes on every input and on the output. It generalises the fixed 4:1 selector to N inputs of width w, and adds built-in selection (fixed-priority or round-robin), a registered output stage and a transfer counter. It sits between several producers and one shared consumer in the lab datapaths.

## Interface
- w, 32, data width per channel
- n, 4, number of input channels (n >= 2)
- rr, 1, arbitration mode: 1 = round-robin, 0 = fixed priority (lowest index wins)
- sw, $clog2(n), width of the source index (derived; not overridden)
- cw, 16, width of the transfer counter

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  n  per-channel request; bit k belongs to channel k
- in_data  input  n*w  flattened data; channel k occupies bits [k*w +: w]
- in_ready  output  n  per-channel accept, one-hot or zero
- out_valid  output  1  output register holds a word
- out_data  output  w  registered data
- out_src  output  sw  index of the channel that supplied out_data
- out_ready  input  1  consumer accept
- xfer_cnt  output  cw  count of completed output transfers; wraps modulo 2^cw

## Operation
- Output transfer happens when out_valid && out_ready. Input transfer on channel k happens when in_valid[k] && in_ready[k].
- load = !out_valid || out_ready. The register may accept a new word only when load = 1.
- Grant:
  - Computed combinationally from in_valid and ptr.
  - rr=1: search starts at channel (ptr+1) mod n and proceeds upward with wrap; the first channel with in_valid set wins.
  - rr=0: the lowest-index channel with in_valid set wins; ptr is ignored.
- in_ready = onehot(grant) when load && |in_valid; otherwise all zero. in_ready never depends on in_ready. It may depend on out_ready combinationally.
- On an input transfer: out_data <= in_data[grant], out_src <= grant, out_valid <= 1. If rr=1, ptr <= grant.
- Output transfer with no input transfer: out_valid <= 0. out_data and out_src hold their values.
- Output transfer and input transfer in the same cycle: the register reloads and out_valid stays 1. This gives full throughput of one word per cycle.
- xfer_cnt increments by 1 on each output transfer; it rolls over from 2^cw-1 to 0.
- ptr holds whenever no input transfer occurs. A channel that drops valid loses its turn and is not remembered.
- Producers must hold in_valid and in_data stable until accepted. This is not checked.

## Timing
- Reset (rst_n low, asynchronous) sets out_valid=0, out_data=0, out_src=0, xfer_cnt=0 and ptr=n-1, so the first rr search starts at channel 0. in_ready is 0 while rst_n is low.
- Reset asserted mid-transfer discards the held word. No transfer completes in the cycle where rst_n is low at the clock edge.
- Latency: 1 cycle from input transfer to out_valid, with out_data valid in that same cycle.
- Backpressure:
  - While out_valid=1 and out_ready=0, in_ready=0 and out_data/out_src are stable.
  - Round-robin fairness: with all n channels requesting continuously, each channel is granted exactly once in any n consecutive input transfers.
- Idle (in_valid=0): no state change other than the out_valid drop on an output transfer.

## Test plan
- Reset: with w=8, n=4, drive rst_n=0 asynchronously mid-cycle with out_valid=1. Required: out_valid, out_data, out_src and xfer_cnt read 0 immediately. After release, in_valid=4'b1111 grants channel 0 first.
- Round-robin streaming (rr=1): in_valid=4'b1111, data 8'hA0..A3, out_ready=1 throughout. Required:
  - out_src sequence 0,1,2,3,0,…
  - out_valid held at 1 from cycle 1 onward
  - xfer_cnt=8 after 8 output transfers
- Fixed priority (rr=0): in_valid=4'b1010 held. Required: channel 1 wins every time. Channel 3 is granted only after in_valid[1] drops; it then appears with out_src=3 and out_data=8'hA3.
- Backpressure: load channel 2 (8'h5C), then hold out_ready=0 for 3 cycles with in_valid=4'b1111. Required:
  - in_ready=0 and out_data=8'h5C for those cycles
  - on out_ready=1, that transfer and the next grant (channel 3 under rr) happen in the same cycle
- Sparse and skip (rr=1, ptr=1): in_valid=4'b0001. Required: the grant wraps to channel 0, and ptr becomes 0 afterwards.
- Counter wrap: cw=4, perform 17 output transfers. Required: xfer_cnt=1.

Source files
------------

// File: rtl/mux_arb.sv
// rtl/mux_arb.sv - N-channel valid/ready arbitrating mux with registered output and transfer counter
module mux_arb #(
  parameter int w  = 32,
  parameter int n  = 4,
  parameter bit rr = 1'b1,
  parameter int sw = $clog2(n),
  parameter int cw = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [n-1:0]   in_valid,
  input  logic [n*w-1:0] in_data,
  output logic [n-1:0]   in_ready,
  output logic           out_valid,
  output logic [w-1:0]   out_data,
  output logic [sw-1:0]  out_src,
  input  logic           out_ready,
  output logic [cw-1:0]  xfer_cnt
);

  logic          out_valid_q, out_valid_d;
  logic [w-1:0]  out_data_q,  out_data_d;
  logic [sw-1:0] out_src_q,   out_src_d;
  logic [sw-1:0] ptr_q,       ptr_d;
  logic [cw-1:0] xfer_cnt_q,  xfer_cnt_d;

  logic [sw-1:0] grant;
  logic          found;
  logic          load;
  logic          in_xfer;
  logic          out_xfer;

  // Round-robin search begins one past the last winner; fixed priority scans from 0.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < n; i++) begin
      int idx;
      idx = rr ? ((int'(ptr_q) + 1 + i) % n) : i;
      if (!found && in_valid[idx]) begin
        found = 1'b1;
        grant = sw'(idx);
      end
    end
  end

  assign load     = !out_valid_q || out_ready;
  assign out_xfer = out_valid_q && out_ready;

  always_comb begin
    in_ready = '0;
    if (rst_n && load && found) begin
      in_ready = n'(1) << grant;
    end
  end

  assign in_xfer = |(in_valid & in_ready);

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_src_d   = out_src_q;
    ptr_d       = ptr_q;
    xfer_cnt_d  = xfer_cnt_q + cw'(out_xfer);
    if (out_xfer) begin
      out_valid_d = 1'b0;
    end
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = in_data[int'(grant)*w +: w];
      out_src_d   = grant;
      if (rr) begin
        ptr_d = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr_q       <= sw'(n - 1);
      xfer_cnt_q  <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_src_q   <= out_src_d;
      ptr_q       <= ptr_d;
      xfer_cnt_q  <= xfer_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_src   = out_src_q;
  assign xfer_cnt  = xfer_cnt_q;

endmodule
